// File: rtl/prt_multi_slot.sv
// ---------------------------------------------------------------------------
// prt_multi_slot
//
// Multi-slot packet reference table. Buffers up to NUM_SLOTS complete frames,
// each up to MEM_DEPTH words of DATA_WIDTH bits. A write engine fills one slot
// while an independent read engine drains another slot in the same cycle.
// Each slot tracks valid / busy (reserved for writing) / len. Frames that
// overflow the slot or that are closed empty are rejected with a wr_error
// pulse, and the reserved slot is released.
//
// Ports
//   CLK, RST              clock, asynchronous active-high reset
//   EN/RDY_start_write    reserve the lowest free slot (wr_slot reports it)
//   EN/RDY_write          store write_data into the reserved slot
//   EN/RDY_finish_write   close the frame (commit or reject)
//   wr_error              one-cycle pulse after a rejected finish
//   EN/RDY_start_read     open start_read_slot for reading
//   EN/RDY_read           request the next word of the open slot
//   rd_valid/data/last    registered read response, one cycle after EN_read
//   EN/RDY_invalidate     free invalidate_slot
//   free_count            slots that are neither valid nor reserved
//
// Handshake: every method is an EN/RDY pair. The method fires in a cycle only
// when EN && RDY are both high at the rising edge; EN while RDY is low is
// ignored and changes nothing. RDY never depends on any EN input, only on
// registered state and the method's own argument inputs.
// ---------------------------------------------------------------------------
module prt_multi_slot #(
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 2000,
  parameter int NUM_SLOTS  = 4,
  localparam int SW = $clog2(NUM_SLOTS),
  localparam int LW = $clog2(MEM_DEPTH + 1),
  localparam int CW = $clog2(NUM_SLOTS + 1)
) (
  input  logic                  CLK,
  input  logic                  RST,
  // write engine
  input  logic                  EN_start_write,
  output logic                  RDY_start_write,
  output logic [SW-1:0]         wr_slot,
  input  logic                  EN_write,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic                  RDY_write,
  input  logic                  EN_finish_write,
  output logic                  RDY_finish_write,
  output logic                  wr_error,
  // read engine
  input  logic                  EN_start_read,
  input  logic [SW-1:0]         start_read_slot,
  output logic                  RDY_start_read,
  input  logic                  EN_read,
  output logic                  RDY_read,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  // slot management
  input  logic                  EN_invalidate,
  input  logic [SW-1:0]         invalidate_slot,
  output logic                  RDY_invalidate,
  output logic [CW-1:0]         free_count
);

  localparam int TOTAL = NUM_SLOTS * MEM_DEPTH;
  localparam int AW    = $clog2(TOTAL);

  typedef enum logic {W_IDLE, W_ACTIVE} w_state_t;
  typedef enum logic {R_IDLE, R_ACTIVE} r_state_t;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic [NUM_SLOTS-1:0]  valid;
  logic [NUM_SLOTS-1:0]  busy;
  logic [LW-1:0]         len [NUM_SLOTS];

  logic [LW-1:0]         count;
  logic                  overflow;

  logic [SW-1:0]         rd_slot;
  logic [LW-1:0]         ptr;

  // Frame storage; deliberately not reset.
  logic [DATA_WIDTH-1:0] mem [TOTAL];

  // -------------------------------------------------------------------------
  // Helpers
  // -------------------------------------------------------------------------
  function automatic logic [AW-1:0] addr_of(input logic [SW-1:0] slot,
                                            input logic [LW-1:0] off);
    return AW'(slot) * AW'(MEM_DEPTH) + AW'(off);
  endfunction

  // Guards slot arguments when NUM_SLOTS is not a power of two.
  function automatic logic slot_ok(input logic [SW-1:0] slot);
    return int'(slot) < NUM_SLOTS;
  endfunction

  // -------------------------------------------------------------------------
  // Method fire strobes
  // -------------------------------------------------------------------------
  logic start_write_fire, write_fire, finish_fire;
  logic start_read_fire, read_fire, invalidate_fire;

  assign start_write_fire = EN_start_write  && RDY_start_write;
  assign write_fire       = EN_write        && RDY_write;
  assign finish_fire      = EN_finish_write && RDY_finish_write;
  assign start_read_fire  = EN_start_read   && RDY_start_read;
  assign read_fire        = EN_read         && RDY_read;
  assign invalidate_fire  = EN_invalidate   && RDY_invalidate;

  // -------------------------------------------------------------------------
  // Free-slot search: lowest index wins, count of all free slots
  // -------------------------------------------------------------------------
  logic          free_any;
  logic [SW-1:0] free_idx;

  always_comb begin
    free_any   = 1'b0;
    free_idx   = '0;
    free_count = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!valid[i] && !busy[i]) begin
        free_any   = 1'b1;
        free_idx   = SW'(i);
        free_count = free_count + CW'(1);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Write-side frame accounting. A word written in the same cycle as finish
  // is included in the committed length and in the overflow decision.
  // -------------------------------------------------------------------------
  logic          word_fits;
  logic          store;
  logic [LW-1:0] final_count;
  logic          final_overflow;
  logic          finish_ok;

  assign word_fits      = count < LW'(MEM_DEPTH);
  assign store          = write_fire && word_fits;
  assign final_count    = count + LW'(store);
  assign final_overflow = overflow || (write_fire && !word_fits);
  assign finish_ok      = (final_count != '0) && !final_overflow;

  // -------------------------------------------------------------------------
  // Read-side last-word detection. len of the open slot cannot change while
  // it is being read: it is valid (so not writable) and cannot be invalidated.
  // -------------------------------------------------------------------------
  logic rd_is_last;
  assign rd_is_last = (ptr == len[rd_slot] - LW'(1));

  // -------------------------------------------------------------------------
  // Write engine FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) w_state <= W_IDLE;
    else     w_state <= w_next;
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:   if (start_write_fire) w_next = W_ACTIVE;
      W_ACTIVE: if (finish_fire)      w_next = W_IDLE;
      default:                        w_next = W_IDLE;
    endcase
  end

  always_comb begin
    RDY_start_write  = (w_state == W_IDLE) && free_any;
    RDY_write        = (w_state == W_ACTIVE);
    RDY_finish_write = (w_state == W_ACTIVE);
  end

  // -------------------------------------------------------------------------
  // Read engine FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= R_IDLE;
    else     r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:   if (start_read_fire)         r_next = R_ACTIVE;
      R_ACTIVE: if (read_fire && rd_is_last) r_next = R_IDLE;
      default:                               r_next = R_IDLE;
    endcase
  end

  always_comb begin
    RDY_start_read = (r_state == R_IDLE) && slot_ok(start_read_slot)
                     && valid[start_read_slot];
    RDY_read       = (r_state == R_ACTIVE);
    // The slot currently open for reading is protected from being freed.
    RDY_invalidate = slot_ok(invalidate_slot) && valid[invalidate_slot]
                     && !((r_state == R_ACTIVE) && (rd_slot == invalidate_slot));
  end

  // -------------------------------------------------------------------------
  // Slot table. start_write and finish are mutually exclusive (different
  // write states); invalidate targets a valid slot, which can be neither the
  // reserved slot nor the one being picked, so no two updates collide.
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid <= '0;
      busy  <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) len[i] <= '0;
    end else begin
      if (start_write_fire) busy[free_idx] <= 1'b1;
      if (finish_fire) begin
        busy[wr_slot] <= 1'b0;
        if (finish_ok) begin
          valid[wr_slot] <= 1'b1;
          len[wr_slot]   <= final_count;
        end
      end
      if (invalidate_fire) valid[invalidate_slot] <= 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Write datapath
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_slot  <= '0;
      count    <= '0;
      overflow <= 1'b0;
      wr_error <= 1'b0;
    end else begin
      wr_error <= finish_fire && !finish_ok;
      if (start_write_fire) begin
        wr_slot  <= free_idx;
        count    <= '0;
        overflow <= 1'b0;
      end
      if (write_fire) begin
        if (word_fits) count    <= count + LW'(1);
        else           overflow <= 1'b1;  // sticky until the next start_write
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (store) mem[addr_of(wr_slot, count)] <= write_data;
  end

  // -------------------------------------------------------------------------
  // Read datapath: one registered stage after the memory lookup
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_slot  <= '0;
      ptr      <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_last  <= 1'b0;
    end else begin
      rd_valid <= read_fire;
      rd_last  <= read_fire && rd_is_last;
      if (start_read_fire) begin
        rd_slot <= start_read_slot;
        ptr     <= '0;
      end
      if (read_fire) begin
        rd_data <= mem[addr_of(rd_slot, ptr)];
        ptr     <= ptr + LW'(1);
      end
    end
  end

endmodule

// File: tb/tb_prt_multi_slot.sv
// ---------------------------------------------------------------------------
// tb_prt_multi_slot
//
// Directed bench for prt_multi_slot (DATA_WIDTH=8, MEM_DEPTH=16, NUM_SLOTS=4).
// Inputs change 1 time unit after the rising edge; outputs are sampled there
// too, so registered outputs show the result of the edge just taken and
// combinational RDY outputs are sampled after the arguments settle.
// ---------------------------------------------------------------------------
module tb_prt_multi_slot;

  localparam int DW = 8;
  localparam int MD = 16;
  localparam int NS = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          EN_start_write = 1'b0;
  logic          RDY_start_write;
  logic [1:0]    wr_slot;
  logic          EN_write = 1'b0;
  logic [DW-1:0] write_data = '0;
  logic          RDY_write;
  logic          EN_finish_write = 1'b0;
  logic          RDY_finish_write;
  logic          wr_error;
  logic          EN_start_read = 1'b0;
  logic [1:0]    start_read_slot = '0;
  logic          RDY_start_read;
  logic          EN_read = 1'b0;
  logic          RDY_read;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          rd_last;
  logic          EN_invalidate = 1'b0;
  logic [1:0]    invalidate_slot = '0;
  logic          RDY_invalidate;
  logic [2:0]    free_count;

  int checks = 0;
  int errors = 0;

  prt_multi_slot #(.DATA_WIDTH(DW), .MEM_DEPTH(MD), .NUM_SLOTS(NS)) dut (
    .CLK(CLK), .RST(RST),
    .EN_start_write(EN_start_write), .RDY_start_write(RDY_start_write),
    .wr_slot(wr_slot),
    .EN_write(EN_write), .write_data(write_data), .RDY_write(RDY_write),
    .EN_finish_write(EN_finish_write), .RDY_finish_write(RDY_finish_write),
    .wr_error(wr_error),
    .EN_start_read(EN_start_read), .start_read_slot(start_read_slot),
    .RDY_start_read(RDY_start_read),
    .EN_read(EN_read), .RDY_read(RDY_read),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
    .EN_invalidate(EN_invalidate), .invalidate_slot(invalidate_slot),
    .RDY_invalidate(RDY_invalidate),
    .free_count(free_count)
  );

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state(input string ph);
    chk({ph, "_free_count"},   32'(free_count), 4);
    chk({ph, "_rdy_sw"},       32'(RDY_start_write), 1);
    chk({ph, "_rdy_write"},    32'(RDY_write), 0);
    chk({ph, "_rdy_finish"},   32'(RDY_finish_write), 0);
    chk({ph, "_rdy_sr"},       32'(RDY_start_read), 0);
    chk({ph, "_rdy_read"},     32'(RDY_read), 0);
    chk({ph, "_rdy_inval"},    32'(RDY_invalidate), 0);
    chk({ph, "_rd_valid"},     32'(rd_valid), 0);
    chk({ph, "_rd_data"},      32'(rd_data), 0);
    chk({ph, "_rd_last"},      32'(rd_last), 0);
    chk({ph, "_wr_error"},     32'(wr_error), 0);
    chk({ph, "_wr_slot"},      32'(wr_slot), 0);
  endtask

  // ---------------- drivers ----------------
  task automatic start_write_t(input logic [1:0] exp_slot);
    EN_start_write = 1'b1;
    tick();
    EN_start_write = 1'b0;
    chk("sw_wr_slot", 32'(wr_slot), 32'(exp_slot));
    chk("sw_rdy_write", 32'(RDY_write), 1);
  endtask

  // Writes n words base, base+1, ... with finish on the last word.
  task automatic write_frame(input int n, input logic [7:0] base, input logic [1:0] exp_slot);
    start_write_t(exp_slot);
    for (int i = 0; i < n; i++) begin
      EN_write        = 1'b1;
      write_data      = base + 8'(i);
      EN_finish_write = (i == n - 1);
      tick();
    end
    EN_write        = 1'b0;
    EN_finish_write = 1'b0;
    chk("wf_rdy_write", 32'(RDY_write), 0);
    chk("wf_wr_error", 32'(wr_error), 0);
  endtask

  task automatic start_read_t(input logic [1:0] slot);
    start_read_slot = slot;
    #1;
    chk("sr_rdy", 32'(RDY_start_read), 1);
    EN_start_read = 1'b1;
    tick();
    EN_start_read = 1'b0;
    chk("sr_rdy_read", 32'(RDY_read), 1);
  endtask

  task automatic read_word(input logic [7:0] d, input logic l);
    EN_read = 1'b1;
    tick();
    EN_read = 1'b0;
    chk("rd_valid", 32'(rd_valid), 1);
    chk("rd_data", 32'(rd_data), 32'(d));
    chk("rd_last", 32'(rd_last), 32'(l));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    // Reset
    tick(); tick();
    chk_reset_state("rst0");
    RST = 1'b0;
    tick();
    chk("post_rst_free", 32'(free_count), 4);

    // Frame A1,A2,A3 into slot 0, finish together with A3
    write_frame(3, 8'hA1, 2'd0);
    chk("a_free_count", 32'(free_count), 3);
    chk("a_len0", 32'(dut.len[0]), 3);
    chk("a_rdy_sw", 32'(RDY_start_write), 1);
    start_read_t(2'd0);
    read_word(8'hA1, 1'b0);
    read_word(8'hA2, 1'b0);
    read_word(8'hA3, 1'b1);
    chk("a_rdy_read_after", 32'(RDY_read), 0);
    chk("a_reread_rdy", 32'(RDY_start_read), 1);
    tick();
    chk("a_rd_valid_idle", 32'(rd_valid), 0);
    chk("a_rd_last_idle", 32'(rd_last), 0);

    // Fill remaining slots
    write_frame(2, 8'h11, 2'd1);
    write_frame(2, 8'h21, 2'd2);
    write_frame(2, 8'h31, 2'd3);
    chk("full_free_count", 32'(free_count), 0);
    chk("full_rdy_sw", 32'(RDY_start_write), 0);

    // start_write while full is ignored; invalidate(2) in the same cycle
    EN_start_write  = 1'b1;
    EN_invalidate   = 1'b1;
    invalidate_slot = 2'd2;
    #1;
    chk("inv2_rdy", 32'(RDY_invalidate), 1);
    tick();
    EN_start_write = 1'b0;
    EN_invalidate  = 1'b0;
    chk("inv2_free_count", 32'(free_count), 1);
    chk("inv2_wr_slot_hold", 32'(wr_slot), 3);
    chk("inv2_rdy_write", 32'(RDY_write), 0);
    chk("inv2_rdy_sw", 32'(RDY_start_write), 1);

    // Empty frame into slot 2 is rejected
    start_write_t(2'd2);
    chk("empty_free_busy", 32'(free_count), 0);
    EN_finish_write = 1'b1;
    tick();
    EN_finish_write = 1'b0;
    chk("empty_wr_error", 32'(wr_error), 1);
    chk("empty_free_count", 32'(free_count), 1);
    tick();
    chk("empty_wr_error_gone", 32'(wr_error), 0);

    // Overflow: 17 writes then finish
    start_write_t(2'd2);
    for (int i = 0; i < 17; i++) begin
      EN_write   = 1'b1;
      write_data = 8'hE0 + 8'(i);
      tick();
    end
    EN_write        = 1'b0;
    EN_finish_write = 1'b1;
    tick();
    EN_finish_write = 1'b0;
    chk("ovf_wr_error", 32'(wr_error), 1);
    chk("ovf_free_count", 32'(free_count), 1);
    start_read_slot = 2'd2;
    invalidate_slot = 2'd2;
    #1;
    chk("ovf_not_readable", 32'(RDY_start_read), 0);
    chk("ovf_not_valid", 32'(RDY_invalidate), 0);
    tick();
    chk("ovf_wr_error_pulse", 32'(wr_error), 0);

    // Exactly MEM_DEPTH words is accepted
    write_frame(16, 8'h40, 2'd2);
    chk("full16_free_count", 32'(free_count), 0);
    start_read_t(2'd2);
    for (int i = 0; i < 16; i++) read_word(8'h40 + 8'(i), i == 15);
    invalidate_slot = 2'd2;
    EN_invalidate   = 1'b1;
    tick();
    EN_invalidate   = 1'b0;
    invalidate_slot = 2'd1;
    EN_invalidate   = 1'b1;
    tick();
    EN_invalidate   = 1'b0;
    chk("free_after_inv12", 32'(free_count), 2);

    // Concurrent: write slot 1 (B0..B3) while reading slot 0 (A1..A3)
    EN_start_write  = 1'b1;
    start_read_slot = 2'd0;
    EN_start_read   = 1'b1;
    tick();
    EN_start_write  = 1'b0;
    EN_start_read   = 1'b0;
    chk("cc_wr_slot", 32'(wr_slot), 1);
    chk("cc_rdy_read", 32'(RDY_read), 1);
    for (int i = 0; i < 4; i++) begin
      EN_write        = 1'b1;
      write_data      = 8'hB0 + 8'(i);
      EN_finish_write = (i == 3);
      EN_read         = (i < 3);
      tick();
      if (i < 3) begin
        chk("cc_rd_data", 32'(rd_data), 32'(8'hA1 + 8'(i)));
        chk("cc_rd_last", 32'(rd_last), 32'(i == 2));
      end
    end
    EN_write        = 1'b0;
    EN_finish_write = 1'b0;
    EN_read         = 1'b0;
    chk("cc_rdy_read_end", 32'(RDY_read), 0);
    chk("cc_wr_error", 32'(wr_error), 0);
    chk("cc_free_count", 32'(free_count), 1);

    // Read slot 1; invalidate(1) attempted during the read has no effect
    start_read_t(2'd1);
    read_word(8'hB0, 1'b0);
    invalidate_slot = 2'd1;
    #1;
    chk("rdinv_blocked", 32'(RDY_invalidate), 0);
    EN_invalidate = 1'b1;
    read_word(8'hB1, 1'b0);
    read_word(8'hB2, 1'b0);
    read_word(8'hB3, 1'b1);
    EN_invalidate = 1'b0;
    chk("rdinv_no_effect", 32'(free_count), 1);
    chk("rdinv_rdy_after", 32'(RDY_invalidate), 1);
    EN_invalidate = 1'b1;
    tick();
    EN_invalidate = 1'b0;
    chk("rdinv_done_free", 32'(free_count), 2);
    chk("rdinv_done_rdy", 32'(RDY_invalidate), 0);

    // Reset mid-write (count=5, slot 1) and mid-read (slot 0, after A1)
    EN_start_write  = 1'b1;
    start_read_slot = 2'd0;
    EN_start_read   = 1'b1;
    tick();
    EN_start_write  = 1'b0;
    EN_start_read   = 1'b0;
    chk("mid_wr_slot", 32'(wr_slot), 1);
    for (int i = 0; i < 5; i++) begin
      EN_write   = 1'b1;
      write_data = 8'hC0 + 8'(i);
      EN_read    = (i == 4);
      tick();
    end
    EN_write = 1'b0;
    EN_read  = 1'b0;
    chk("mid_count", 32'(dut.count), 5);
    chk("mid_rd_data", 32'(rd_data), 32'(8'hA1));
    chk("mid_rdy_read", 32'(RDY_read), 1);
    #2;
    RST = 1'b1;
    #1;
    chk_reset_state("rst_mid");
    tick();
    RST = 1'b0;
    tick();
    chk("post_mid_free", 32'(free_count), 4);

    // Normal operation resumes from slot 0
    write_frame(1, 8'h77, 2'd0);
    start_read_t(2'd0);
    read_word(8'h77, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
